// File: rtl/ceespu_wb_arbiter.sv
// Writeback arbiter: two requesters share one registered register-file write port.
// Optional combinational read bypass when CEESPU_WB_BYPASS_EN is defined.
module ceespu_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int SEL_W      = 5,
    parameter int FIXED_PRIO = 0,
    parameter int CNT_W      = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_req0_valid,
    input  logic [SEL_W-1:0]  I_req0_sel,
    input  logic [DATA_W-1:0] I_req0_data,
    output logic              O_req0_ready,
    input  logic              I_req1_valid,
    input  logic [SEL_W-1:0]  I_req1_sel,
    input  logic [DATA_W-1:0] I_req1_data,
    output logic              O_req1_ready,
    output logic              O_we,
    output logic [SEL_W-1:0]  O_selD,
    output logic [DATA_W-1:0] O_dataD,
`ifdef CEESPU_WB_BYPASS_EN
    input  logic [SEL_W-1:0]  I_selA,
    input  logic [SEL_W-1:0]  I_selB,
    input  logic [DATA_W-1:0] I_dataA,
    input  logic [DATA_W-1:0] I_dataB,
    output logic [DATA_W-1:0] O_fwdA,
    output logic [DATA_W-1:0] O_fwdB,
`endif
    output logic [CNT_W-1:0]  O_stall_cnt
);

    logic lastGrant;
    logic grant0, grant1;
    logic stall;

    // Port 1 wins a collision under fixed priority, or when port 0 was served last.
    always_comb begin
        grant1 = I_req1_valid && (!I_req0_valid || (FIXED_PRIO != 0) || !lastGrant);
        grant0 = I_req0_valid && !grant1;
        stall  = (I_req0_valid && !grant0) || (I_req1_valid && !grant1);
    end

    assign O_req0_ready = grant0;
    assign O_req1_ready = grant1;

    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            lastGrant <= 1'b1;
            O_we      <= 1'b0;
            O_selD    <= '0;
            O_dataD   <= '0;
        end else begin
            O_we <= grant0 || grant1;
            if (grant0) begin
                O_selD    <= I_req0_sel;
                O_dataD   <= I_req0_data;
                lastGrant <= 1'b0;
            end else if (grant1) begin
                O_selD    <= I_req1_sel;
                O_dataD   <= I_req1_data;
                lastGrant <= 1'b1;
            end
        end
    end

    // Saturates at all-ones so a long stall never reads back as a small count.
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst)
            O_stall_cnt <= '0;
        else if (stall && (O_stall_cnt != {CNT_W{1'b1}}))
            O_stall_cnt <= O_stall_cnt + 1'b1;
    end

`ifdef CEESPU_WB_BYPASS_EN
    // Covers the cycle where the write is still in flight to the register file.
    assign O_fwdA = (O_we && (O_selD == I_selA)) ? O_dataD : I_dataA;
    assign O_fwdB = (O_we && (O_selD == I_selB)) ? O_dataD : I_dataB;
`endif

endmodule

// File: tb/tb_ceespu_wb_arbiter.sv
// Directed bench for ceespu_wb_arbiter: round-robin, fixed-priority and a narrow-counter instance.
module tb_ceespu_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

    logic              I_clk = 1'b0;
    logic              I_rst = 1'b0;
    logic              v0 = 1'b0, v1 = 1'b0;
    logic [SEL_W-1:0]  s0 = '0, s1 = '0;
    logic [DATA_W-1:0] d0 = '0, d1 = '0;

    logic              r0, r1, we;
    logic [SEL_W-1:0]  selD;
    logic [DATA_W-1:0] dataD;
    logic [15:0]       cnt;

    logic              fr0, fr1, fwe;
    logic [SEL_W-1:0]  fselD;
    logic [DATA_W-1:0] fdataD;
    logic [15:0]       fcnt;

    logic              sr0, sr1, swe;
    logic [SEL_W-1:0]  sselD;
    logic [DATA_W-1:0] sdataD;
    logic [2:0]        scnt;

`ifdef CEESPU_WB_BYPASS_EN
    logic [SEL_W-1:0]  selA = '0, selB = '0;
    logic [DATA_W-1:0] dataA = '0, dataB = '0;
    logic [DATA_W-1:0] fwdA, fwdB, ffwdA, ffwdB, sfwdA, sfwdB;
`endif

    int checks = 0;
    int failures = 0;

    always #5 I_clk = ~I_clk;

    ceespu_wb_arbiter #(.FIXED_PRIO(0)) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_req0_valid(v0), .I_req0_sel(s0), .I_req0_data(d0), .O_req0_ready(r0),
        .I_req1_valid(v1), .I_req1_sel(s1), .I_req1_data(d1), .O_req1_ready(r1),
        .O_we(we), .O_selD(selD), .O_dataD(dataD),
`ifdef CEESPU_WB_BYPASS_EN
        .I_selA(selA), .I_selB(selB), .I_dataA(dataA), .I_dataB(dataB),
        .O_fwdA(fwdA), .O_fwdB(fwdB),
`endif
        .O_stall_cnt(cnt));

    ceespu_wb_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_req0_valid(v0), .I_req0_sel(s0), .I_req0_data(d0), .O_req0_ready(fr0),
        .I_req1_valid(v1), .I_req1_sel(s1), .I_req1_data(d1), .O_req1_ready(fr1),
        .O_we(fwe), .O_selD(fselD), .O_dataD(fdataD),
`ifdef CEESPU_WB_BYPASS_EN
        .I_selA(selA), .I_selB(selB), .I_dataA(dataA), .I_dataB(dataB),
        .O_fwdA(ffwdA), .O_fwdB(ffwdB),
`endif
        .O_stall_cnt(fcnt));

    ceespu_wb_arbiter #(.FIXED_PRIO(0), .CNT_W(3)) dut_sat (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_req0_valid(v0), .I_req0_sel(s0), .I_req0_data(d0), .O_req0_ready(sr0),
        .I_req1_valid(v1), .I_req1_sel(s1), .I_req1_data(d1), .O_req1_ready(sr1),
        .O_we(swe), .O_selD(sselD), .O_dataD(sdataD),
`ifdef CEESPU_WB_BYPASS_EN
        .I_selA(selA), .I_selB(selB), .I_dataA(dataA), .I_dataB(dataB),
        .O_fwdA(sfwdA), .O_fwdB(sfwdB),
`endif
        .O_stall_cnt(scnt));

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    task automatic do_reset();
        #1;
        I_rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        step();
        step();
        I_rst = 1'b1;
    endtask

    task automatic test_reset();
        I_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (we !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b0 || cnt !== 16'd0 || selD !== '0 || dataD !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: we=%b r0=%b r1=%b cnt=%0d selD=%0d dataD=%h, want all zero",
                         i, we, r0, r1, cnt, selD, dataD);
            end
        end
        I_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (we !== 1'b0 || r0 !== 1'b0 || r1 !== 1'b0 || cnt !== 16'd0) begin
                failures++;
                $display("FAIL idle cyc%0d: we=%b r0=%b r1=%b cnt=%0d, want 0 0 0 0", i, we, r0, r1, cnt);
            end
        end
    endtask

    task automatic test_single_port0();
        v0 = 1'b1; s0 = 5'd5; d0 = 32'hDEADBEEF;
        #1;
        checks++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            failures++;
            $display("FAIL single_ready: r0=%b r1=%b, want 1 0", r0, r1);
        end
        step();
        v0 = 1'b0;
        checks++;
        if (we !== 1'b1 || selD !== 5'd5 || dataD !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_write: we=%b selD=%0d dataD=%h, want 1 5 deadbeef", we, selD, dataD);
        end
        step();
        checks++;
        if (we !== 1'b0 || selD !== 5'd5 || dataD !== 32'hDEADBEEF || cnt !== 16'd0) begin
            failures++;
            $display("FAIL single_after: we=%b selD=%0d dataD=%h cnt=%0d, want 0 5 deadbeef 0", we, selD, dataD, cnt);
        end
    endtask

    task automatic test_round_robin();
        logic exp0 [4];
        logic [SEL_W-1:0] expSel [4];
        exp0 = '{1'b1, 1'b0, 1'b1, 1'b0};
        expSel = '{5'd1, 5'd2, 5'd1, 5'd2};
        do_reset();
        v0 = 1'b1; s0 = 5'd1; d0 = 32'h11111111;
        v1 = 1'b1; s1 = 5'd2; d1 = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (r0 !== exp0[i] || r1 !== !exp0[i]) begin
                failures++;
                $display("FAIL rr_grant%0d: r0=%b r1=%b, want %b %b", i, r0, r1, exp0[i], !exp0[i]);
            end
            step();
            checks++;
            if (we !== 1'b1 || selD !== expSel[i] || dataD !== (exp0[i] ? 32'h11111111 : 32'h22222222)) begin
                failures++;
                $display("FAIL rr_write%0d: we=%b selD=%0d dataD=%h, want 1 %0d", i, we, selD, dataD, expSel[i]);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        checks++;
        if (cnt !== 16'd4) begin
            failures++;
            $display("FAIL rr_stall_cnt: got %0d want 4", cnt);
        end
        step();
        checks++;
        if (we !== 1'b0 || cnt !== 16'd4) begin
            failures++;
            $display("FAIL rr_idle: we=%b cnt=%0d, want 0 4", we, cnt);
        end
    endtask

    // Last grant above went to port 1, so port 0 wins first; register 0 is an ordinary target.
    task automatic test_same_dest();
        v0 = 1'b1; s0 = 5'd0; d0 = 32'hAAAA0000;
        v1 = 1'b1; s1 = 5'd0; d1 = 32'hBBBB0000;
        #1;
        checks++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            failures++;
            $display("FAIL same_grant0: r0=%b r1=%b, want 1 0", r0, r1);
        end
        step();
        v0 = 1'b0;
        checks++;
        if (we !== 1'b1 || selD !== 5'd0 || dataD !== 32'hAAAA0000) begin
            failures++;
            $display("FAIL same_first: we=%b selD=%0d dataD=%h, want 1 0 aaaa0000", we, selD, dataD);
        end
        step();
        v1 = 1'b0;
        checks++;
        if (we !== 1'b1 || selD !== 5'd0 || dataD !== 32'hBBBB0000) begin
            failures++;
            $display("FAIL same_final: we=%b selD=%0d dataD=%h, want 1 0 bbbb0000", we, selD, dataD);
        end
        step();
    endtask

    task automatic test_fixed_prio_and_saturation();
        do_reset();
        v0 = 1'b1; s0 = 5'd1; d0 = 32'h11111111;
        v1 = 1'b1; s1 = 5'd2; d1 = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (fr0 !== 1'b0 || fr1 !== 1'b1) begin
                failures++;
                $display("FAIL fp_grant%0d: r0=%b r1=%b, want 0 1", i, fr0, fr1);
            end
            step();
            checks++;
            if (fwe !== 1'b1 || fselD !== 5'd2 || fcnt !== 16'(i + 1)) begin
                failures++;
                $display("FAIL fp_write%0d: we=%b selD=%0d cnt=%0d, want 1 2 %0d", i, fwe, fselD, fcnt, i + 1);
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        checks++;
        if (scnt !== 3'd7) begin
            failures++;
            $display("FAIL sat_cnt: got %0d want 7", scnt);
        end
        step();
        checks++;
        if (scnt !== 3'd7 || fcnt !== 16'd10) begin
            failures++;
            $display("FAIL sat_hold: scnt=%0d fcnt=%0d, want 7 10", scnt, fcnt);
        end
    endtask

    task automatic test_async_reset();
        v1 = 1'b1; s1 = 5'd9; d1 = 32'hCAFEF00D;
        step();
        v1 = 1'b0;
        checks++;
        if (we !== 1'b1 || selD !== 5'd9) begin
            failures++;
            $display("FAIL areset_pre: we=%b selD=%0d, want 1 9", we, selD);
        end
        #1;
        I_rst = 1'b0;
        #1;
        checks++;
        if (we !== 1'b0 || selD !== '0 || dataD !== '0 || cnt !== 16'd0) begin
            failures++;
            $display("FAIL areset_clear: we=%b selD=%0d dataD=%h cnt=%0d, want all zero", we, selD, dataD, cnt);
        end
        #1;
        I_rst = 1'b1;
        step();
    endtask

`ifdef CEESPU_WB_BYPASS_EN
    task automatic test_bypass();
        selA = 5'd7; dataA = 32'h0;
        selB = 5'd3; dataB = 32'h55;
        v1 = 1'b1; s1 = 5'd7; d1 = 32'h1234;
        step();
        v1 = 1'b0;
        checks++;
        if (fwdA !== 32'h1234 || fwdB !== 32'h55) begin
            failures++;
            $display("FAIL bypass_hit: fwdA=%h fwdB=%h, want 1234 55", fwdA, fwdB);
        end
        step();
        checks++;
        if (fwdA !== 32'h0) begin
            failures++;
            $display("FAIL bypass_after: fwdA=%h, want 0", fwdA);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_port0();
        test_round_robin();
        test_same_dest();
        test_fixed_prio_and_saturation();
        test_async_reset();
`ifdef CEESPU_WB_BYPASS_EN
        test_bypass();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
